// File: rtl/sim_uart_fifo.sv
// Buffered UART: TX and RX FIFOs around a serial transmitter and receiver, all on clk_50.
// Both FSMs drive their state onto debug outputs. Each FIFO side uses valid/ready: a transfer happens on the edge where both are high.

module sim_uart_fifo_buf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       data_i,
  output logic [WIDTH-1:0]       data_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  // A pop in the same cycle frees the slot a push into a full buffer needs.
  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != FULL) || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
endmodule

module sim_uart_fifo #(
  parameter int DIVISOR    = 434,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk_50,
  input  logic                        reset,
  input  logic                        rx_i,
  output logic                        tx_o,
  input  logic [DATA_BITS-1:0]        tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic [DATA_BITS-1:0]        rx_data,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic                        rx_parity_err,
  output logic                        rx_frame_err,
  output logic                        rx_overrun,
  output logic [$clog2(FIFO_DEPTH):0] tx_count,
  output logic [$clog2(FIFO_DEPTH):0] rx_count,
  output logic [2:0]                  tx_state_o,
  output logic [2:0]                  rx_state_o
);
  localparam int CNTW = $clog2(FIFO_DEPTH) + 1;
  localparam int CW   = $clog2(DIVISOR * STOP_BITS);
  localparam logic [CNTW-1:0] FULL     = CNTW'(FIFO_DEPTH);
  localparam logic [CW-1:0]   BIT_END  = CW'(DIVISOR - 1);
  localparam logic [CW-1:0]   HALF_END = CW'(DIVISOR / 2 - 1);
  // The IDLE cycle that pops the next character supplies the last stop cycle.
  localparam logic [CW-1:0]   STOP_END = CW'(DIVISOR * STOP_BITS - 2);
  localparam logic [2:0]      LAST_BIT = 3'(DATA_BITS - 1);
  localparam logic            HAS_PAR  = (PARITY != 0);
  localparam logic            PAR_ODD  = (PARITY == 1);

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_PARITY    = 3'd3,
    RX_STOP      = 3'd4,
    RX_WAIT_HIGH = 3'd5
  } rx_state_e;

  // ---------------- TX path ----------------
  logic [DATA_BITS-1:0] tx_head;
  logic                 tx_pop;
  tx_state_e            tx_state_q, tx_state_d;
  logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
  logic [2:0]           tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_par_q, tx_par_d;
  logic                 tx_o_q, tx_o_d;

  assign tx_ready = (tx_count != FULL);

  sim_uart_fifo_buf #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_i   (clk_50),
    .rst_i   (reset),
    .push_i  (tx_valid && tx_ready),
    .pop_i   (tx_pop),
    .data_i  (tx_data),
    .data_o  (tx_head),
    .count_o (tx_count)
  );

  // tx_o is registered from the current state, so the line lags the FSM by one cycle.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_pop     = 1'b0;
    tx_o_d     = 1'b1;
    case (tx_state_q)
      TX_IDLE: begin
        if (tx_count != '0) begin
          tx_pop     = 1'b1;
          tx_shift_d = tx_head;
          tx_par_d   = (^tx_head) ^ PAR_ODD;
          tx_cnt_d   = '0;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        tx_o_d = 1'b0;
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = TX_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      TX_DATA: begin
        tx_o_d = tx_shift_q[0];
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d   = '0;
          tx_shift_d = tx_shift_q >> 1;
          tx_bit_d   = tx_bit_q + 3'd1;
          if (tx_bit_q == LAST_BIT) tx_state_d = HAS_PAR ? TX_PARITY : TX_STOP;
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      TX_PARITY: begin
        tx_o_d = tx_par_q;
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_STOP;
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == STOP_END) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk_50) begin
    if (reset) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_o_q     <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      tx_o_q     <= tx_o_d;
    end
  end

  assign tx_o       = tx_o_q;
  assign tx_state_o = tx_state_q;

  // ---------------- RX path ----------------
  logic                 rx_sync1_q, rx_sync2_q, rx_prev_q;
  logic                 rx_s;
  rx_state_e            rx_state_q, rx_state_d;
  logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
  logic [2:0]           rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_perr_q, rx_perr_d;
  logic                 rx_push, rx_pop, rx_overrun_q;
  logic [DATA_BITS+1:0] rx_head;

  assign rx_s = rx_sync2_q;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_perr_d  = rx_perr_q;
    rx_push    = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_s) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HALF_END) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_perr_d  = 1'b0;
          rx_state_d = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_END) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s, rx_shift_q[DATA_BITS-1:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == LAST_BIT) rx_state_d = HAS_PAR ? RX_PARITY : RX_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      RX_PARITY: begin
        if (rx_cnt_q == BIT_END) begin
          rx_cnt_d   = '0;
          rx_perr_d  = rx_s ^ (^rx_shift_q) ^ PAR_ODD;
          rx_state_d = RX_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_END) begin
          rx_cnt_d   = '0;
          rx_push    = 1'b1;
          rx_state_d = rx_s ? RX_IDLE : RX_WAIT_HIGH;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      RX_WAIT_HIGH: begin
        if (rx_s) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk_50) begin
    if (reset) begin
      rx_sync1_q   <= 1'b1;
      rx_sync2_q   <= 1'b1;
      rx_prev_q    <= 1'b1;
      rx_state_q   <= RX_IDLE;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      rx_perr_q    <= 1'b0;
      rx_overrun_q <= 1'b0;
    end else begin
      rx_sync1_q   <= rx_i;
      rx_sync2_q   <= rx_sync1_q;
      rx_prev_q    <= rx_sync2_q;
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      rx_perr_q    <= rx_perr_d;
      rx_overrun_q <= rx_push && (rx_count == FULL) && !rx_pop;
    end
  end

  sim_uart_fifo_buf #(.WIDTH(DATA_BITS + 2), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk_i   (clk_50),
    .rst_i   (reset),
    .push_i  (rx_push),
    .pop_i   (rx_pop),
    .data_i  ({rx_shift_q, rx_perr_q, ~rx_s}),
    .data_o  (rx_head),
    .count_o (rx_count)
  );

  // Head fields are forced to zero while empty so stale memory never shows.
  assign rx_valid      = (rx_count != '0);
  assign rx_pop        = rx_valid && rx_ready;
  assign rx_data       = rx_valid ? rx_head[DATA_BITS+1:2] : '0;
  assign rx_parity_err = rx_valid && rx_head[1];
  assign rx_frame_err  = rx_valid && rx_head[0];
  assign rx_overrun    = rx_overrun_q;
  assign rx_state_o    = rx_state_q;
endmodule
